key_direction_encoder: RTL
==========================

# key_direction_encoder

Converts the four raw, bouncing, active-low board pushbuttons into a clean 3-bit direction code. The code feeds the seven-segment direction decoder directly. Each key is synchronized and debounced, and release-to-press edges are detected. The most recent accepted press is latched as the current direction, with a one-cycle strobe for game logic that needs per-press events.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change; legal range 1..2^CNT_W-1
- CNT_W, 16, debounce counter width
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high; one clock, all state reset on i_clk rising edge while high
- i_key  in  4  raw pushbuttons, active-low: bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT
- i_enable  in  1  press acceptance enable; low discards press events
- i_clear  in  1  single-cycle request to return o_dec to NONE
- o_dec  out  3  latched direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 NONE
- o_valid  out  1  one-cycle pulse coincident with o_dec update on an accepted press

## Operation
- Per key: 2-flop synchronizer (s1, s2), debounced level `stable`, counter `cnt`.
- When s2 == stable, cnt <= 0.
- When s2 != stable and cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0. Otherwise cnt <= cnt+1.
- A single-cycle glitch on s2 restarts the count. It never flips stable.
- Press event for key k: stable[k] transitions 1->0. Release events are ignored.
- Same-cycle events: priority UP > DOWN > LEFT > RIGHT. Lower-priority events that cycle are dropped, not queued.
- Accepted press requires i_enable == 1 in the event cycle. Accepting sets o_dec <= key index and o_valid <= 1 on the next edge.
- Re-pressing the current direction still pulses o_valid. o_dec is unchanged in value.
- i_enable low: debouncing continues, events are discarded. A key held across i_enable rising produces no event.
- i_clear: o_dec <= 4 (NONE). If an accepted press occurs the same cycle, the press wins and o_valid pulses.
- Holding a key never auto-repeats.

## Timing
- Reset values:
  - o_dec = 3'd4
  - o_valid = 0
  - s1 = s2 = stable = 4'b1111 (released)
  - all cnt = 0
- Press latency: a key level first sampled low at edge N gives o_valid high and o_dec updated after edge N+2+DEBOUNCE_CYCLES. That is 2 sync edges, DEBOUNCE_CYCLES count edges, and 1 output register edge.
- o_valid is high for exactly one cycle per accepted press.
- Reset mid-operation: counters and stable levels clear. A key held low through reset deassertion is seen as a new press, with o_valid after the full latency measured from the first post-reset edge.
- Minimum press-to-press spacing: 2*DEBOUNCE_CYCLES cycles (press, release, press).
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

## Structure
- Shared package `dir_pkg` holds:
  - `typedef enum logic [2:0] dir_e` {DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3, DIR_NONE=4}
  - key index constants
  - This package is the same encoding the seven-segment decoder consumes.
- Sub-module `key_debounce` holds one key's synchronizer, counter and stable level, and outputs a press-edge pulse. It is instantiated 4 times.
- Top level holds the priority encode, enable/clear gating and output registers.

## Test plan
Test plan runs use DEBOUNCE_CYCLES=4, which gives a latency of 7.

1. Reset, all keys high, no activity -> o_dec=4 and o_valid=0 for 50 cycles.
2. i_key[2] low at edge 10, held -> o_valid=1 only after edge 17, o_dec=2; no further pulses while held.
3. i_key[0] bounce low/high/low at 2-cycle intervals, then held -> exactly one o_valid, o_dec=0, timed 7 edges after the last transition.
4. i_key[1] and i_key[3] low on the same edge -> single o_valid with o_dec=1. RIGHT is dropped, and o_dec stays 1 after both are released.
5. Key 3 held while i_enable=0, then i_enable=1 -> no o_valid and o_dec unchanged. Release and press again -> o_valid with o_dec=3.
6. i_clear pulse with o_dec=3 -> o_dec=4 next cycle. Then i_clear in the same cycle as an accepted UP press -> o_dec=0 with o_valid=1. i_rst asserted while cnt is mid-count -> o_dec=4 and no stale press event.

Source files
------------

// File: rtl/dir_pkg.sv
// dir_pkg: direction encoding shared with the seven-segment direction decoder.
package dir_pkg;
    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_NONE  = 3'd4
    } dir_e;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int NUM_KEYS  = 4;
    function automatic dir_e prio_dir(input logic [NUM_KEYS-1:0] p);
        return p[KEY_UP]    ? DIR_UP    :
               p[KEY_DOWN]  ? DIR_DOWN  :
               p[KEY_LEFT]  ? DIR_LEFT  :
               p[KEY_RIGHT] ? DIR_RIGHT : DIR_NONE;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces one active-low key, pulsing o_press
// for one cycle when the debounced level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_s1       <= i_key;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
    assign o_press = r_stable_d & ~r_stable;
endmodule

// File: rtl/key_direction_encoder.sv
// key_direction_encoder: four debounced active-low keys to a latched 3-bit
// direction code with a one-cycle strobe per accepted press.
module key_direction_encoder
    import dir_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key,
    input  logic                i_enable,
    input  logic                i_clear,
    output logic [2:0]          o_dec,
    output logic                o_valid
);
    logic [NUM_KEYS-1:0] w_press;
    logic                w_accept;
    dir_e                r_dec;
    logic                r_valid;
    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : gen_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_deb (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_key  (i_key[k]),
                .o_press(w_press[k])
            );
        end
    endgenerate
    assign w_accept = i_enable & |w_press;
    // An accepted press overrides a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dec   <= DIR_NONE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            r_dec   <= w_accept ? prio_dir(w_press) : i_clear ? DIR_NONE : r_dec;
        end
    end
    assign o_dec   = r_dec;
    assign o_valid = r_valid;
endmodule
